// File: rtl/lsq_fwdless_arb.sv
// Load/store queue arbiter without store-to-load forwarding.
// Loads wait behind older same-word stores; stores issue in order once released.
module lsq_fwdless_arb #(
  parameter int LQ_DEPTH     = 4,
  parameter int SQ_DEPTH     = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int ID_W         = 3,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_load,
  input  logic                in_store,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_be,
  input  logic [2:0]          in_fn3,
  input  logic [ID_W-1:0]     in_id,
  input  logic                release_i,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_load,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [DATA_W-1:0]   out_data,
  output logic [DATA_W/8-1:0] out_be,
  output logic [2:0]          out_fn3,
  output logic [ID_W-1:0]     out_id,
  output logic                empty,
  output logic                sq_empty,
  output logic                released_pending,
  output logic                starve_force
);

  localparam int LAW = $clog2(LQ_DEPTH);
  localparam int SAW = $clog2(SQ_DEPTH);
  localparam int BW  = DATA_W / 8;
  localparam int STW = $clog2(STARVE_LIMIT + 1);
  localparam logic [STW-1:0] ST_MAX = STW'(STARVE_LIMIT);

  logic [ADDR_W-1:0]   lq_addr_q [LQ_DEPTH];
  logic [2:0]          lq_fn3_q  [LQ_DEPTH];
  logic [ID_W-1:0]     lq_id_q   [LQ_DEPTH];
  logic [SQ_DEPTH-1:0] lq_mask_q [LQ_DEPTH];
  logic [SQ_DEPTH-1:0] lq_mask_d [LQ_DEPTH];

  logic [ADDR_W-1:0]   sq_addr_q [SQ_DEPTH];
  logic [DATA_W-1:0]   sq_data_q [SQ_DEPTH];
  logic [BW-1:0]       sq_be_q   [SQ_DEPTH];
  logic [2:0]          sq_fn3_q  [SQ_DEPTH];
  logic [ID_W-1:0]     sq_id_q   [SQ_DEPTH];

  logic [LAW-1:0] lq_head_q, lq_head_d;
  logic [LAW-1:0] lq_tail_q, lq_tail_d;
  logic [LAW:0]   lq_cnt_q,  lq_cnt_d;
  logic [SAW-1:0] sq_head_q, sq_head_d;
  logic [SAW-1:0] sq_tail_q, sq_tail_d;
  logic [SAW:0]   sq_cnt_q,  sq_cnt_d;
  logic [SAW:0]   sq_rel_q,  sq_rel_d;
  logic [STW-1:0] starve_q,  starve_d;
  logic           hold_q,    hold_d;
  logic           hold_st_q, hold_st_d;

  logic                lq_full, sq_full;
  logic                ld_push, st_push;
  logic                ld_pop, st_pop;
  logic                ld_ok, st_ok;
  logic                conflict, starve_hit;
  logic                sel_st, fire, rel_inc;
  logic [SQ_DEPTH-1:0] sq_occ, st_match, pop_clr;
  logic [ADDR_W-1:0]   ld_addr;

  assign lq_full = lq_cnt_q[LAW];
  assign sq_full = sq_cnt_q[SAW];

  assign in_ready = in_load ? ~lq_full : ~sq_full;
  assign ld_push  = in_valid & in_load & ~lq_full & ~flush;
  assign st_push  = in_valid & in_store & ~in_load & ~sq_full & ~flush;

  // Slot i is live when its distance from head is below the count
  always_comb begin
    sq_occ   = '0;
    st_match = '0;
    ld_addr  = lq_addr_q[lq_head_q];
    for (int i = 0; i < SQ_DEPTH; i++) begin
      sq_occ[i]   = {1'b0, SAW'(i) - sq_head_q} < sq_cnt_q;
      st_match[i] = sq_addr_q[i][ADDR_W-1:2] == ld_addr[ADDR_W-1:2];
    end
  end

  assign conflict   = |(lq_mask_q[lq_head_q] & st_match);
  assign ld_ok      = (lq_cnt_q != '0) & ~conflict;
  assign st_ok      = sq_rel_q != '0;
  assign starve_hit = starve_q == ST_MAX;

  assign sel_st    = hold_q ? hold_st_q : (st_ok & (~ld_ok | starve_hit));
  assign out_valid = hold_q | ld_ok | st_ok;
  assign fire      = out_valid & out_ready;
  assign ld_pop    = fire & ~sel_st;
  assign st_pop    = fire & sel_st;
  assign rel_inc   = release_i & (sq_rel_q != sq_cnt_q);
  assign pop_clr   = SQ_DEPTH'(st_pop) << sq_head_q;

  assign out_load = ~sel_st;
  assign out_addr = sel_st ? sq_addr_q[sq_head_q] : ld_addr;
  assign out_data = sel_st ? sq_data_q[sq_head_q] : '0;
  assign out_be   = sel_st ? sq_be_q[sq_head_q] : '0;
  assign out_fn3  = sel_st ? sq_fn3_q[sq_head_q] : lq_fn3_q[lq_head_q];
  assign out_id   = sel_st ? sq_id_q[sq_head_q] : lq_id_q[lq_head_q];

  assign empty            = (lq_cnt_q == '0) & (sq_cnt_q == '0);
  assign sq_empty         = sq_cnt_q == '0;
  assign released_pending = st_ok;
  assign starve_force     = out_valid & sel_st & starve_hit;

  always_comb begin
    lq_head_d = lq_head_q + LAW'(ld_pop);
    lq_tail_d = lq_tail_q + LAW'(ld_push);
    lq_cnt_d  = lq_cnt_q + (LAW+1)'(ld_push) - (LAW+1)'(ld_pop);
    if (flush) begin
      lq_tail_d = lq_head_d;
      lq_cnt_d  = '0;
    end
  end

  // Flush keeps the released prefix and rewinds the tail behind it
  always_comb begin
    sq_head_d = sq_head_q + SAW'(st_pop);
    sq_rel_d  = sq_rel_q + (SAW+1)'(rel_inc) - (SAW+1)'(st_pop);
    sq_tail_d = sq_tail_q + SAW'(st_push);
    sq_cnt_d  = sq_cnt_q + (SAW+1)'(st_push) - (SAW+1)'(st_pop);
    if (flush) begin
      sq_cnt_d  = sq_rel_d;
      sq_tail_d = sq_head_d + sq_rel_d[SAW-1:0];
    end
  end

  always_comb begin
    for (int i = 0; i < LQ_DEPTH; i++) begin
      lq_mask_d[i] = flush ? '0 : (lq_mask_q[i] & ~pop_clr);
    end
    if (ld_push) begin
      lq_mask_d[lq_tail_q] = sq_occ & ~pop_clr;
    end
  end

  always_comb begin
    starve_d  = starve_q;
    hold_d    = out_valid & ~out_ready & ~flush;
    hold_st_d = sel_st;
    if (st_pop) begin
      starve_d = '0;
    end else if (ld_pop & st_ok) begin
      starve_d = starve_hit ? ST_MAX : starve_q + STW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lq_head_q <= '0;
      lq_tail_q <= '0;
      lq_cnt_q  <= '0;
      sq_head_q <= '0;
      sq_tail_q <= '0;
      sq_cnt_q  <= '0;
      sq_rel_q  <= '0;
      starve_q  <= '0;
      hold_q    <= 1'b0;
      hold_st_q <= 1'b0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_mask_q[i] <= '0;
      end
    end else begin
      lq_head_q <= lq_head_d;
      lq_tail_q <= lq_tail_d;
      lq_cnt_q  <= lq_cnt_d;
      sq_head_q <= sq_head_d;
      sq_tail_q <= sq_tail_d;
      sq_cnt_q  <= sq_cnt_d;
      sq_rel_q  <= sq_rel_d;
      starve_q  <= starve_d;
      hold_q    <= hold_d;
      hold_st_q <= hold_st_d;
      lq_mask_q <= lq_mask_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && ld_push) begin
      lq_addr_q[lq_tail_q] <= in_addr;
      lq_fn3_q[lq_tail_q]  <= in_fn3;
      lq_id_q[lq_tail_q]   <= in_id;
    end
    if (rst_n && st_push) begin
      sq_addr_q[sq_tail_q] <= in_addr;
      sq_data_q[sq_tail_q] <= in_data;
      sq_be_q[sq_tail_q]   <= in_be;
      sq_fn3_q[sq_tail_q]  <= in_fn3;
      sq_id_q[sq_tail_q]   <= in_id;
    end
  end

endmodule

// File: tb/tb_lsq_fwdless_arb.sv
// Randomized bench for lsq_fwdless_arb against a queue-level model.
// Directed sequences first, then random traffic with flush/reset.
module tb_lsq_fwdless_arb;

  localparam int LQD = 4;
  localparam int SQD = 4;
  localparam int LIM = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic        in_load = 1'b0, in_store = 1'b0;
  logic [31:0] in_addr = '0, in_data = '0;
  logic [3:0]  in_be = '0;
  logic [2:0]  in_fn3 = '0, in_id = '0;
  logic        release_i = 1'b0, flush = 1'b0;
  logic        out_valid, out_ready = 1'b0, out_load;
  logic [31:0] out_addr, out_data;
  logic [3:0]  out_be;
  logic [2:0]  out_fn3, out_id;
  logic        empty, sq_empty, released_pending, starve_force;

  always #5 clk = ~clk;

  lsq_fwdless_arb #(
    .LQ_DEPTH(LQD), .SQ_DEPTH(SQD), .ADDR_W(32), .DATA_W(32),
    .ID_W(3), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_store(in_store),
    .in_addr(in_addr), .in_data(in_data), .in_be(in_be),
    .in_fn3(in_fn3), .in_id(in_id),
    .release_i(release_i), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_load(out_load),
    .out_addr(out_addr), .out_data(out_data), .out_be(out_be),
    .out_fn3(out_fn3), .out_id(out_id),
    .empty(empty), .sq_empty(sq_empty),
    .released_pending(released_pending), .starve_force(starve_force)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [2:0]  fn3;
    logic [2:0]  id;
    int          uid;
  } st_t;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  fn3;
    logic [2:0]  id;
    int          bound;
  } ld_t;

  st_t sq[$];
  ld_t lq[$];
  int  nrel, starve, next_uid;
  bit  lock, lock_st;
  int  n_run, n_fail;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    sq.delete();
    lq.delete();
    nrel = 0;
    starve = 0;
    lock = 0;
    lock_st = 0;
  endtask

  // Load blocks on any older store still queued to the same word
  function automatic bit blocked();
    bit b = 0;
    foreach (sq[j])
      if (sq[j].uid < lq[0].bound && sq[j].addr[31:2] == lq[0].addr[31:2])
        b = 1;
    return b;
  endfunction

  task automatic step();
    bit ldok, stok, selst, ev, fire, acc_ld, acc_st;
    st_t s;
    ld_t l;
    #1;
    ldok  = (lq.size() > 0) && !blocked();
    stok  = nrel > 0;
    selst = lock ? lock_st : (stok && (!ldok || starve == LIM));
    ev    = lock || ldok || stok;
    chk("out_valid", out_valid, ev);
    if (ev) begin
      chk("out_load", out_load, !selst);
      if (selst) begin
        chk("st_addr", out_addr, sq[0].addr);
        chk("st_data", out_data, sq[0].data);
        chk("st_be", out_be, sq[0].be);
        chk("st_fn3", out_fn3, sq[0].fn3);
        chk("st_id", out_id, sq[0].id);
      end else begin
        chk("ld_addr", out_addr, lq[0].addr);
        chk("ld_data", out_data, 0);
        chk("ld_be", out_be, 0);
        chk("ld_fn3", out_fn3, lq[0].fn3);
        chk("ld_id", out_id, lq[0].id);
      end
    end
    chk("in_ready", in_ready, in_load ? (lq.size() < LQD) : (sq.size() < SQD));
    chk("empty", empty, lq.size() == 0 && sq.size() == 0);
    chk("sq_empty", sq_empty, sq.size() == 0);
    chk("rel_pend", released_pending, nrel > 0);
    chk("starve_force", starve_force, ev && selst && starve == LIM);
    if (!rst_n) begin
      mreset();
    end else begin
      fire   = ev && out_ready;
      acc_ld = in_valid && in_load && lq.size() < LQD && !flush;
      acc_st = in_valid && in_store && !in_load && sq.size() < SQD && !flush;
      if (fire) begin
        if (selst) begin
          void'(sq.pop_front());
          nrel--;
          starve = 0;
        end else begin
          void'(lq.pop_front());
          if (stok) starve = (starve < LIM) ? starve + 1 : LIM;
        end
      end
      if (release_i && nrel < sq.size()) nrel++;
      if (flush) begin
        lq.delete();
        while (sq.size() > nrel) void'(sq.pop_back());
        lock = 0;
      end else begin
        lock    = ev && !out_ready;
        lock_st = selst;
        if (acc_ld) begin
          l.addr = in_addr; l.fn3 = in_fn3; l.id = in_id; l.bound = next_uid;
          lq.push_back(l);
        end
        if (acc_st) begin
          s.addr = in_addr; s.data = in_data; s.be = in_be;
          s.fn3 = in_fn3; s.id = in_id; s.uid = next_uid;
          next_uid++;
          sq.push_back(s);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drv(input bit v, input bit ld, input logic [31:0] a,
                     input bit rel, input bit fl, input bit rdy);
    in_valid  = v;
    in_load   = ld;
    in_store  = ~ld;
    in_addr   = a;
    in_data   = $urandom;
    in_be     = 4'($urandom);
    in_fn3    = 3'($urandom);
    in_id     = 3'($urandom);
    release_i = rel;
    flush     = fl;
    out_ready = rdy;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    next_uid = 0;
    mreset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Same-word load waits for its older store
    drv(1, 0, 32'h100, 0, 0, 1);
    drv(1, 1, 32'h100, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 1);
    chk("blk_valid", out_valid, 0);
    drv(0, 0, 0, 1, 0, 1);
    drv(0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 1);

    // Different word issues ahead of unreleased store
    do_reset();
    drv(1, 0, 32'h100, 0, 0, 1);
    drv(1, 1, 32'h104, 0, 0, 1);
    chk("bypass_load", out_load, 1);
    drv(0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 1, 0, 1);
    drv(0, 0, 0, 0, 0, 1);

    // Starvation override
    do_reset();
    drv(1, 0, 32'h200, 0, 0, 0);
    drv(1, 1, 32'h300, 0, 0, 0);
    drv(1, 1, 32'h304, 0, 0, 0);
    drv(1, 1, 32'h308, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) drv(0, 0, 0, 0, 0, 1);

    // Flush keeps released stores
    do_reset();
    for (int i = 0; i < 4; i++) drv(1, 0, 32'h400 + 4 * i, i < 2, 0, 0);
    drv(1, 1, 32'h500, 0, 0, 0);
    drv(1, 1, 32'h504, 0, 0, 0);
    drv(1, 0, 32'h600, 0, 1, 0);
    chk("flush_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) drv(0, 0, 0, 0, 0, 1);

    // Stall with new loads arriving
    do_reset();
    drv(1, 1, 32'h700, 0, 0, 0);
    for (int i = 0; i < 5; i++) drv(1, 1, 32'h710 + 4 * i, 0, 0, 0);
    for (int i = 0; i < 5; i++) drv(0, 0, 0, 0, 0, 1);

    // Reset while filling the load queue
    for (int i = 0; i < 3; i++) drv(1, 1, 32'h800 + 4 * i, 0, 0, 0);
    rst_n = 1'b0;
    drv(1, 1, 32'h80c, 0, 0, 0);
    rst_n = 1'b1;
    chk("rst_empty", empty, 1);
    chk("rst_valid", out_valid, 0);
    drv(0, 0, 0, 0, 0, 0);

    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drv($urandom_range(0, 9) < 6, $urandom_range(0, 1),
          32'h100 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3),
          $urandom_range(0, 9) < 3, $urandom_range(0, 29) == 0,
          $urandom_range(0, 9) < 7);
    end
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
